// File: rtl/cdb_broadcaster_pkg.sv
// Shared definitions for the common-data-bus transmit side.
//   NUM_FU      number of result producers on the bus
//   RESULT_W    result data width
//   TAG_W       reservation-station label width
//   LABEL_NONE  label meaning "no producer / value already valid"
//   fuIdx_e     producer index on require/requireAC (ALU, MUL, DIV, load/store)
//   wrapInc     increment modulo n, used for the round-robin pointer
package cdb_broadcaster_pkg;

  localparam int unsigned NUM_FU   = 4;
  localparam int unsigned RESULT_W = 32;
  localparam int unsigned TAG_W    = 4;

  localparam logic [TAG_W-1:0] LABEL_NONE = '0;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_LS  = 2'd3
  } fuIdx_e;

  function automatic int unsigned wrapInc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_pick.sv
// Combinational round-robin picker.
// Grants the first set bit of valid at or after index ptr, wrapping modulo
// NUM_SRC.
//   valid  in   NUM_SRC  occupied slots
//   ptr    in   PTR_W    highest-priority index this cycle
//   grant  out  NUM_SRC  one-hot grant (all zero when nothing is valid)
//   any    out  1        some slot was granted
module rr_pick
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_FU,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic               any
);

  always_comb begin
    logic [PTR_W-1:0] idx;
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_SRC);
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus transmit side. Each producer owns a one-entry result slot;
// one occupied slot per cycle is chosen round-robin and driven onto the
// registered broadcast seen by the register file and reservation stations.
//   clk        in   1                rising-edge clock
//   nRST       in   1                asynchronous active-low reset
//   require    in   NUM_SRC          per-unit result valid
//   dataIn     in   NUM_SRC*DATA_W   per-unit result, slice i = [i*DATA_W +: DATA_W]
//   labelIn    in   NUM_SRC*LABEL_W  per-unit producer label, slice i = [i*LABEL_W +: LABEL_W]
//   requireAC  out  NUM_SRC          per-unit accept (combinational)
//   BCEN       out  1                broadcast valid
//   BClabel    out  LABEL_W          broadcast label
//   BCdata     out  DATA_W           broadcast data
//   busy       out  NUM_SRC          slot occupied
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_FU,
  parameter int unsigned DATA_W  = RESULT_W,
  parameter int unsigned LABEL_W = TAG_W
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [NUM_SRC-1:0]         require,
  input  logic [NUM_SRC*DATA_W-1:0]  dataIn,
  input  logic [NUM_SRC*LABEL_W-1:0] labelIn,
  output logic [NUM_SRC-1:0]         requireAC,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic [NUM_SRC-1:0]         busy
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] slotValid;
  logic [LABEL_W-1:0] slotLabel [NUM_SRC];
  logic [DATA_W-1:0]  slotData  [NUM_SRC];

  logic [PTR_W-1:0]   ptr;
  logic [NUM_SRC-1:0] grant;
  logic               anyValid;
  logic [PTR_W-1:0]   grantIdx;
  logic [LABEL_W-1:0] grantLabel;
  logic [DATA_W-1:0]  grantData;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) uPick (
    .valid (slotValid),
    .ptr   (ptr),
    .grant (grant),
    .any   (anyValid)
  );

  // A slot being broadcast this cycle is free again at the edge, so it may
  // take the next result at the same time (one result per unit per cycle).
  always_comb begin
    requireAC = require & {NUM_SRC{nRST}} & (~slotValid | grant);
    busy      = slotValid;
  end

  always_comb begin
    grantIdx   = '0;
    grantLabel = '0;
    grantData  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        grantIdx   = PTR_W'(i);
        grantLabel = slotLabel[i];
        grantData  = slotData[i];
      end
    end
  end

  // Label-none results are accepted to release the producer but never
  // occupy the slot, so they can never reach the bus.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      slotValid <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        slotLabel[i] <= '0;
        slotData[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (requireAC[i]) begin
          slotValid[i] <= (labelIn[i*LABEL_W +: LABEL_W] != LABEL_W'(LABEL_NONE));
          slotLabel[i] <= labelIn[i*LABEL_W +: LABEL_W];
          slotData[i]  <= dataIn[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slotValid[i] <= 1'b0;
        end
      end
    end
  end

  // Idle cycles clear the label but keep the last data word on the bus.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr     <= '0;
      BCEN    <= 1'b0;
      BClabel <= '0;
      BCdata  <= '0;
    end else if (anyValid) begin
      ptr     <= PTR_W'(wrapInc(32'(grantIdx), NUM_SRC));
      BCEN    <= 1'b1;
      BClabel <= grantLabel;
      BCdata  <= grantData;
    end else begin
      BCEN    <= 1'b0;
      BClabel <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed stimulus pushes the
// hand-ordered broadcast sequence into a scoreboard queue; a negedge monitor
// pops and compares every BCEN cycle.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  typedef struct packed {
    logic [LW-1:0] l;
    logic [DW-1:0] d;
  } item_t;

  // Broadcast order for the back-pressure test, starting with ptr = 1.
  localparam logic [3:0] T5_ORDER [15] = '{4'h5, 4'h8, 4'hC, 4'h1, 4'h6, 4'h9, 4'hD, 4'h2,
                                          4'h7, 4'hA, 4'hE, 4'h3, 4'hB, 4'hF, 4'h4};

  logic               clk = 1'b0;
  logic               nRST;
  logic [NS-1:0]      require;
  logic [NS*DW-1:0]   dataIn;
  logic [NS*LW-1:0]   labelIn;
  logic [NS-1:0]      requireAC;
  logic               BCEN;
  logic [LW-1:0]      BClabel;
  logic [DW-1:0]      BCdata;
  logic [NS-1:0]      busy;

  item_t         expQ[$];
  item_t         srcQ[NS][$];
  logic [NS-1:0] accLog[$];
  int            checks = 0;
  int            passes = 0;

  cdb_broadcaster #(
    .NUM_SRC (NS),
    .DATA_W  (DW),
    .LABEL_W (LW)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .require   (require),
    .dataIn    (dataIn),
    .labelIn   (labelIn),
    .requireAC (requireAC),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic expectBc(input logic [LW-1:0] l, input logic [DW-1:0] d);
    expQ.push_back({l, d});
  endtask

  task automatic addSrc(input int unsigned i, input logic [LW-1:0] l, input logic [DW-1:0] d);
    srcQ[i].push_back({l, d});
  endtask

  function automatic bit anyPending();
    for (int unsigned i = 0; i < NS; i++) if (srcQ[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Producer model: presents the head of each queue, holds it until accepted.
  task automatic runSources(input int maxCycles);
    int n = 0;
    logic [NS-1:0] acc;
    accLog.delete();
    while (anyPending() && n < maxCycles) begin
      @(negedge clk);
      for (int unsigned i = 0; i < NS; i++) begin
        if (srcQ[i].size() != 0) begin
          require[i]          = 1'b1;
          labelIn[i*LW +: LW] = srcQ[i][0].l;
          dataIn[i*DW +: DW]  = srcQ[i][0].d;
        end else begin
          require[i] = 1'b0;
        end
      end
      #1;
      acc = requireAC;
      accLog.push_back(acc);
      for (int unsigned i = 0; i < NS; i++)
        if (acc[i] && srcQ[i].size() != 0) void'(srcQ[i].pop_front());
      n++;
    end
    check("sources_accepted", 64'(anyPending()), 64'd0);
    for (int unsigned i = 0; i < NS; i++) srcQ[i].delete();
    @(negedge clk);
    require = '0;
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(expQ.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    check({name, "_idle_after"}, 64'(BCEN), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    item_t e;
    if (BCEN === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("FAIL unexpected_broadcast: got label %0h data %0h, required no broadcast",
                 BClabel, BCdata);
      end else begin
        e = expQ.pop_front();
        check("bc_label", 64'(BClabel), 64'(e.l));
        check("bc_data", 64'(BCdata), 64'(e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    nRST    = 1'b0;
    require = '0;
    dataIn  = '0;
    labelIn = '0;

    // Reset holds off accepts; release accepts all four, broadcast in ptr order
    repeat (2) @(negedge clk);
    require = '1;
    for (int unsigned i = 0; i < NS; i++) begin
      labelIn[i*LW +: LW] = LW'(i + 1);
      dataIn[i*DW +: DW]  = 32'h1000_0000 + i;
    end
    #1;
    check("rst_requireAC", 64'(requireAC), 64'h0);
    check("rst_BCEN", 64'(BCEN), 64'h0);
    check("rst_BClabel", 64'(BClabel), 64'h0);
    check("rst_BCdata", 64'(BCdata), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    nRST = 1'b1;
    #1;
    check("release_requireAC", 64'(requireAC), 64'hF);
    for (int unsigned i = 0; i < NS; i++) expectBc(LW'(i + 1), 32'h1000_0000 + i);
    @(negedge clk);
    require = '0;
    check("t1_busy_full", 64'(busy), 64'hF);
    check("t1_bcen_latency", 64'(BCEN), 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_bcen_burst", 64'(BCEN), 64'h1);
    end
    @(negedge clk);
    check("t1_bcen_idle", 64'(BCEN), 64'h0);
    check("t1_busy_empty", 64'(busy), 64'h0);

    // Contention with ptr = 0: labels 1..4 back to back
    for (int unsigned i = 0; i < NS; i++) begin
      addSrc(i, LW'(i + 1), 32'hC0DE_0000 + i);
      expectBc(LW'(i + 1), 32'hC0DE_0000 + i);
    end
    runSources(10);
    check("t3_all_accepted", 64'(accLog[0]), 64'hF);
    waitDrain("t3", 10);

    // Single MUL result: accept same cycle, broadcast two cycles later
    @(negedge clk);
    require       = 4'b0010;
    labelIn[7:4]  = 4'h5;
    dataIn[63:32] = 32'h0000_002A;
    expectBc(4'h5, 32'h0000_002A);
    #1;
    check("t2_requireAC", 64'(requireAC), 64'b0010);
    @(negedge clk);
    require = '0;
    check("t2_bcen_n1", 64'(BCEN), 64'h0);
    check("t2_busy_n1", 64'(busy), 64'b0010);
    @(negedge clk);
    check("t2_bcen_n2", 64'(BCEN), 64'h1);
    check("t2_label_n2", 64'(BClabel), 64'h5);
    check("t2_data_n2", 64'(BCdata), 64'h2A);
    @(negedge clk);
    check("t2_bcen_n3", 64'(BCEN), 64'h0);

    // Fairness: ALU streams, MUL once (ptr = 2)
    for (int unsigned k = 1; k <= 3; k++) addSrc(int'(FU_ALU), LW'(k), 32'hA000_0000 + k);
    addSrc(int'(FU_MUL), 4'h7, 32'h7777_7777);
    expectBc(4'h1, 32'hA000_0001);
    expectBc(4'h7, 32'h7777_7777);
    expectBc(4'h2, 32'hA000_0002);
    expectBc(4'h3, 32'hA000_0003);
    runSources(12);
    waitDrain("t4", 12);

    // Back-pressure: every unit streaming (ptr = 1)
    for (int unsigned k = 0; k < 4; k++) begin
      addSrc(int'(FU_ALU), LW'(4'h1 + k), 32'h5000_0001 + k);
      addSrc(int'(FU_DIV), LW'(4'h8 + k), 32'h5000_0008 + k);
      addSrc(int'(FU_LS),  LW'(4'hC + k), 32'h5000_000C + k);
    end
    for (int unsigned k = 0; k < 3; k++) addSrc(int'(FU_MUL), LW'(4'h5 + k), 32'h5000_0005 + k);
    for (int k = 0; k < 15; k++) expectBc(T5_ORDER[k], 32'h5000_0000 | 32'(T5_ORDER[k]));
    runSources(30);
    check("t5_acc_cycle1", 64'(accLog[1]), 64'b0010);
    check("t5_acc_cycle2_mul_blocked", 64'(accLog[2]), 64'b0100);
    waitDrain("t5", 20);

    // Label 0: accepted, never stored or broadcast
    @(negedge clk);
    require        = 4'b0001;
    labelIn[3:0]   = 4'h0;
    dataIn[31:0]   = 32'hDEAD_BEEF;
    #1;
    check("t6_label0_accepted", 64'(requireAC), 64'b0001);
    @(negedge clk);
    require = '0;
    check("t6_label0_not_stored", 64'(busy), 64'h0);
    repeat (3) begin
      @(negedge clk);
      check("t6_label0_no_bc", 64'(BCEN), 64'h0);
    end

    // Mid-operation reset with three slots still full (ptr = 1)
    require = '1;
    for (int unsigned i = 0; i < NS; i++) begin
      labelIn[i*LW +: LW] = LW'(i + 1);
      dataIn[i*DW +: DW]  = 32'h6000_0000 + i;
    end
    expectBc(4'h2, 32'h6000_0001);
    @(negedge clk);
    require = '0;
    check("t6_busy_full", 64'(busy), 64'hF);
    @(negedge clk);
    #2;
    check("t6_bc_before_rst", 64'(BCEN), 64'h1);
    check("t6_busy_before_rst", 64'(busy), 64'b1101);
    nRST = 1'b0;
    #1;
    check("t6_rst_BCEN", 64'(BCEN), 64'h0);
    check("t6_rst_BClabel", 64'(BClabel), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    nRST = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t6_no_stale_bc", 64'(BCEN), 64'h0);
    end
    check("final_scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
